// File: rtl/countdown_controller.sv
// -----------------------------------------------------------------------------
// countdown_controller
//
// Sequencer for a cascaded chain of digit timers. It loads every digit with 9s
// (reconfig), then paces decrement requests into the least-significant digit
// from a clock prescaler. It also inserts queued penalty decrements, supports
// pause/resume and abort, and flags expiry once every digit reads zero and the
// borrow ripple has settled.
//
// Parameters
//   NUM_DIGITS    : number of chained digit timers (borrow-settle window)
//   TICK_DIV      : clk cycles per regular decrement (>= NUM_DIGITS+2)
//   PENALTY_TICKS : decrements queued per penalty pulse
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-low reset
//   start      in   pulse: load digits and begin the countdown
//   pause      in   pulse: toggle RUN/PAUSE
//   abort      in   pulse: return to IDLE
//   penalty    in   pulse: queue PENALTY_TICKS extra decrements
//   digits_in  in   numOut of every digit, LSD in [3:0]
//   reconfig   out  load-all-9s strobe (high in LOAD)
//   decrement  out  decrement request to the LSD
//   running    out  high in RUN
//   paused     out  high in PAUSE
//   expired    out  high in EXPIRED
//   state      out  IDLE=0, LOAD=1, RUN=2, PAUSE=3, EXPIRED=4
// -----------------------------------------------------------------------------
module countdown_controller #(
    parameter int NUM_DIGITS    = 4,
    parameter int TICK_DIV      = 50000000,
    parameter int PENALTY_TICKS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    abort,
    input  logic                    penalty,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic                    reconfig,
    output logic                    decrement,
    output logic                    running,
    output logic                    paused,
    output logic                    expired,
    output logic [2:0]              state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_PAUSE   = 3'd3;
    localparam logic [2:0] ST_EXPIRED = 3'd4;

    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam int SETTLE_W = $clog2(NUM_DIGITS + 2);

    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0]  PRESC_PRE   = PRESC_W'(TICK_DIV - 2);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(NUM_DIGITS + 1);
    localparam logic [9:0]          PEN_ADD     = 10'(PENALTY_TICKS);

    // Penalty queue update: optional take of one entry, optional add, saturating at 255.
    function automatic logic [7:0] pend_next(input logic [7:0] cur, input logic take, input logic add);
        logic [9:0] sum;
        sum = {2'b00, cur} - {9'd0, take} + (add ? PEN_ADD : 10'd0);
        if (sum > 10'd255) begin
            pend_next = 8'd255;
        end else begin
            pend_next = sum[7:0];
        end
    endfunction

    logic [2:0]          state_r;
    logic [2:0]          state_s;
    logic [PRESC_W-1:0]  presc_r;
    logic [PRESC_W-1:0]  presc_s;
    logic [SETTLE_W-1:0] settle_r;
    logic [SETTLE_W-1:0] settle_s;
    logic [7:0]          pend_r;
    logic [7:0]          pend_s;
    logic                dec_r;
    logic                dec_s;
    logic                take_s;
    logic                abort_s;
    logic                tick_due_s;
    logic                tick_next_s;
    logic                settle_idle_s;
    logic                digits_zero_s;

    assign tick_due_s    = (presc_r == PRESC_LAST);
    // A penalty issued one cycle before a tick would make two back-to-back pulses.
    assign tick_next_s   = (presc_r == PRESC_PRE);
    assign settle_idle_s = (settle_r == {SETTLE_W{1'b0}});
    assign digits_zero_s = (digits_in == {(4*NUM_DIGITS){1'b0}});
    // LOAD is a fixed one-cycle step that ignores every input, abort included.
    assign abort_s       = abort && (state_r != ST_LOAD);

    assign state     = state_r;
    assign decrement = dec_r;

    // Next-state, prescaler, settle window, penalty queue and decrement request.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        pend_s  = pend_r;
        dec_s   = 1'b0;
        take_s  = 1'b0;
        if (settle_idle_s) begin
            settle_s = {SETTLE_W{1'b0}};
        end else begin
            settle_s = settle_r - SETTLE_W'(1);
        end

        if (abort_s) begin
            state_s  = ST_IDLE;
            presc_s  = {PRESC_W{1'b0}};
            settle_s = {SETTLE_W{1'b0}};
            pend_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_s  = ST_RUN;
                    presc_s  = {PRESC_W{1'b0}};
                    settle_s = {SETTLE_W{1'b0}};
                    pend_s   = 8'd0;
                end
                ST_RUN: begin
                    if (!pause && settle_idle_s && !dec_r && digits_zero_s) begin
                        state_s = ST_EXPIRED;
                        pend_s  = 8'd0;
                    end else begin
                        // The pause edge still ends a RUN cycle, so the prescaler advances.
                        if (tick_due_s) begin
                            presc_s  = {PRESC_W{1'b0}};
                            dec_s    = 1'b1;
                            settle_s = SETTLE_LOAD;
                        end else begin
                            presc_s = presc_r + PRESC_W'(1);
                            if ((pend_r != 8'd0) && settle_idle_s && !tick_next_s) begin
                                dec_s    = 1'b1;
                                settle_s = SETTLE_LOAD;
                                take_s   = 1'b1;
                            end else begin
                                dec_s = 1'b0;
                            end
                        end
                        pend_s = pend_next(pend_r, take_s, penalty && !pause);
                        if (pause) begin
                            state_s = ST_PAUSE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_EXPIRED: begin
                    if (start) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_EXPIRED;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    presc_s  = {PRESC_W{1'b0}};
                    settle_s = {SETTLE_W{1'b0}};
                    pend_s   = 8'd0;
                end
            endcase
        end
    end

    // State registers and registered Moore status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            presc_r  <= {PRESC_W{1'b0}};
            settle_r <= {SETTLE_W{1'b0}};
            pend_r   <= 8'd0;
            dec_r    <= 1'b0;
            reconfig <= 1'b0;
            running  <= 1'b0;
            paused   <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state_r  <= state_s;
            presc_r  <= presc_s;
            settle_r <= settle_s;
            pend_r   <= pend_s;
            dec_r    <= dec_s;
            reconfig <= (state_s == ST_LOAD);
            running  <= (state_s == ST_RUN);
            paused   <= (state_s == ST_PAUSE);
            expired  <= (state_s == ST_EXPIRED);
        end
    end

endmodule

// File: tb/tb_countdown_controller.sv
// -----------------------------------------------------------------------------
// Testbench for countdown_controller (TICK_DIV=10, NUM_DIGITS=4, PENALTY_TICKS=3).
// A cycle-level behavioural model tracks "edges left until the next tick",
// "edges since the last decrement" and the penalty count; every cycle the DUT
// outputs are compared against it, and directed checks pin key cycles.
// -----------------------------------------------------------------------------
module tb_countdown_controller;

    localparam int TD  = 10;
    localparam int ND  = 4;
    localparam int PT  = 3;
    localparam int BIG = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause;
    logic        abort;
    logic        penalty;
    logic [15:0] digits;
    logic        reconfig;
    logic        decrement;
    logic        running;
    logic        paused;
    logic        expired;
    logic [2:0]  state;

    int tests    = 0;
    int fails    = 0;
    int dec_seen = 0;
    int cyc      = 0;
    int d0       = 0;

    // model state: mode code, RUN edges left to the tick edge, edges since last issue, queue
    int   m_st   = 0;
    int   m_left = TD;
    int   m_gap  = BIG;
    int   m_pend = 0;
    logic m_dec  = 1'b0;

    always #5 clk = ~clk;

    countdown_controller #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .PENALTY_TICKS(PT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .penalty  (penalty),
        .digits_in(digits),
        .reconfig (reconfig),
        .decrement(decrement),
        .running  (running),
        .paused   (paused),
        .expired  (expired),
        .state    (state)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_left = TD;
        m_gap  = BIG;
        m_pend = 0;
    endtask

    // One rising edge of the specified behaviour, applied to the model.
    task automatic model_edge();
        logic gap_ok;
        logic ndec;
        gap_ok = (m_gap >= ND + 1);
        ndec   = 1'b0;
        if (m_gap < BIG) m_gap = m_gap + 1;
        if (!rst) begin
            m_st = 0;
            model_clear();
        end else begin
            case (m_st)
                0: begin
                    if (abort) model_clear();
                    else if (start) m_st = 1;
                end
                1: begin
                    m_st = 2;
                    model_clear();
                end
                2: begin
                    if (abort) begin
                        m_st = 0;
                        model_clear();
                    end else if (!pause && gap_ok && !m_dec && digits == 16'h0000) begin
                        m_st   = 4;
                        m_pend = 0;
                    end else begin
                        if (m_left == 1) begin
                            ndec   = 1'b1;
                            m_left = TD;
                        end else begin
                            m_left = m_left - 1;
                            if (m_pend > 0 && gap_ok && m_left != 1) begin
                                ndec   = 1'b1;
                                m_pend = m_pend - 1;
                            end
                        end
                        if (ndec) m_gap = 0;
                        if (!pause && penalty) m_pend = (m_pend + PT > 255) ? 255 : m_pend + PT;
                        if (pause) m_st = 3;
                    end
                end
                3: begin
                    if (abort) begin
                        m_st = 0;
                        model_clear();
                    end else if (pause) m_st = 2;
                end
                4: begin
                    if (abort) begin
                        m_st = 0;
                        model_clear();
                    end else if (start) m_st = 1;
                end
                default: m_st = 0;
            endcase
        end
        m_dec = ndec;
    endtask

    // One clock cycle: model follows the edge, then outputs are compared at the negedge.
    task automatic step1();
        logic [2:0] st3;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        start   = 1'b0;
        pause   = 1'b0;
        abort   = 1'b0;
        penalty = 1'b0;
        if (decrement === 1'b1) dec_seen++;
        st3 = m_st[2:0];
        check("outputs", {8'd0, state, reconfig, decrement, running, paused, expired},
              {8'd0, st3, (m_st == 1), m_dec, (m_st == 2), (m_st == 3), (m_st == 4)});
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step1();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; penalty = 1'b0;
        digits = 16'h9999;
        stepn(2);
        check("reset_state", {13'd0, state}, 16'd0);
        rst = 1'b1;

        // start: LOAD for one cycle, then ticks every 10 RUN cycles
        start = 1'b1; step1();
        check("load_reconfig", {15'd0, reconfig}, 16'd1);
        check("load_state", {13'd0, state}, 16'd1);
        step1();
        check("run_state", {13'd0, state}, 16'd2);
        stepn(9);
        check("before_tick", {15'd0, decrement}, 16'd0);
        step1();
        check("first_tick", {15'd0, decrement}, 16'd1);
        step1();
        check("tick_width", {15'd0, decrement}, 16'd0);
        stepn(8); step1();
        check("second_tick", {15'd0, decrement}, 16'd1);

        // pause 4 cycles after a tick, hold 25, resume: tick 6 cycles later
        stepn(3);
        pause = 1'b1; step1();
        check("pause_state", {13'd0, state}, 16'd3);
        d0 = dec_seen; stepn(25);
        check("no_dec_paused", 16'(dec_seen - d0), 16'd0);
        pause = 1'b1; step1();
        check("resume_state", {13'd0, state}, 16'd2);
        stepn(5);
        check("resume_wait", {15'd0, decrement}, 16'd0);
        step1();
        check("resume_tick", {15'd0, decrement}, 16'd1);

        // penalty right after a tick: first extra pulse 6 cycles after the tick
        penalty = 1'b1; step1();
        stepn(4);
        check("pen_wait", {15'd0, decrement}, 16'd0);
        step1();
        check("pen_first", {15'd0, decrement}, 16'd1);
        d0 = dec_seen; stepn(24);
        check("pen_window", 16'(dec_seen - d0), 16'd5);
        d0 = dec_seen; stepn(10);
        check("pen_drained", 16'(dec_seen - d0), 16'd1);

        // penalty queued just before a tick: the tick wins, penalty waits
        stepn(7);
        penalty = 1'b1; step1();
        step1();
        check("pretick_hold", {15'd0, decrement}, 16'd0);
        step1();
        check("collide_tick", {15'd0, decrement}, 16'd1);
        d0 = dec_seen; stepn(30);
        check("collide_window", 16'(dec_seen - d0), 16'd6);

        // expiry six cycles after the last decrement, then restart
        digits = 16'h0000;
        stepn(5);
        check("pre_expire", {13'd0, state}, 16'd2);
        step1();
        check("expire_state", {13'd0, state}, 16'd4);
        check("expire_flag", {15'd0, expired}, 16'd1);
        d0 = dec_seen; stepn(10);
        check("expired_quiet", 16'(dec_seen - d0), 16'd0);
        digits = 16'h9999;
        start = 1'b1; step1();
        check("restart_reconfig", {15'd0, reconfig}, 16'd1);
        step1();
        check("restart_run", {13'd0, state}, 16'd2);

        // abort together with start in RUN while a penalty is pending
        step1();
        penalty = 1'b1; step1();
        step1();
        check("abort_pre_pen", {15'd0, decrement}, 16'd1);
        abort = 1'b1; start = 1'b1; step1();
        check("abort_state", {13'd0, state}, 16'd0);
        check("abort_dec", {15'd0, decrement}, 16'd0);
        d0 = dec_seen; stepn(20);
        check("abort_quiet", 16'(dec_seen - d0), 16'd0);

        // reset mid-RUN with two penalties still queued
        start = 1'b1; step1();
        step1();
        penalty = 1'b1; step1();
        step1();
        check("rst_pre_pen", {15'd0, decrement}, 16'd1);
        rst = 1'b0; stepn(2);
        check("rst_state", {13'd0, state}, 16'd0);
        check("rst_dec", {15'd0, decrement}, 16'd0);
        rst = 1'b1;
        d0 = dec_seen; stepn(30);
        check("rst_quiet", 16'(dec_seen - d0), 16'd0);
        check("rst_idle", {13'd0, state}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
